// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with a req/rdy word bus.
// Issues word loads/stores, stalls the pipe while the bus waits, and
// registers the MEM->WB bundle. fwd_data_o previews the next mem_out_o.
// Optional build macro: MEM_MISALIGN_CHECK_EN (misaligned access trap, code 4).
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   stall_i, flush_i        MEM->WB hold / clear
//   busy_o, fwd_data_o      stall request, forwarding value
//   exe_*_i                 EXE->MEM bundle (exe_out_i = byte address)
//   bus_*                   single-master bus, req held until rdy
//   mem_*_o                 MEM->WB register
module mem_stage #(
    parameter int WORD_DATA_WIDTH = 32,
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int MEM_OP_BUS      = 2,
    parameter int CTRL_OP_BUS     = 2,
    parameter int REG_ADDR_BUS    = 5,
    parameter int ISA_EXP_BUS     = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    output logic                       busy_o,
    output logic [WORD_DATA_WIDTH-1:0] fwd_data_o,
    input  logic [WORD_ADDR_WIDTH-1:0] exe_pc_i,
    input  logic                       exe_en_i,
    input  logic                       exe_br_flag_i,
    input  logic [MEM_OP_BUS-1:0]      exe_mem_op_i,
    input  logic [WORD_DATA_WIDTH-1:0] exe_mem_wr_data_i,
    input  logic [CTRL_OP_BUS-1:0]     exe_ctrl_op_i,
    input  logic [REG_ADDR_BUS-1:0]    exe_dst_addr_i,
    input  logic                       exe_gpr_wre_i,
    input  logic [ISA_EXP_BUS-1:0]     exe_exp_code_i,
    input  logic [WORD_DATA_WIDTH-1:0] exe_out_i,
    output logic                       bus_req_o,
    output logic                       bus_rw_o,
    output logic [WORD_ADDR_WIDTH-1:0] bus_addr_o,
    output logic [WORD_DATA_WIDTH-1:0] bus_wr_data_o,
    input  logic [WORD_DATA_WIDTH-1:0] bus_rd_data_i,
    input  logic                       bus_rdy_i,
    output logic [WORD_ADDR_WIDTH-1:0] mem_pc_o,
    output logic                       mem_en_o,
    output logic                       mem_br_flag_o,
    output logic [CTRL_OP_BUS-1:0]     mem_ctrl_op_o,
    output logic [REG_ADDR_BUS-1:0]    mem_dst_addr_o,
    output logic                       mem_gpr_wre_o,
    output logic [ISA_EXP_BUS-1:0]     mem_exp_code_o,
    output logic [WORD_DATA_WIDTH-1:0] mem_out_o
);

    localparam logic [MEM_OP_BUS-1:0]  OP_LOAD      = MEM_OP_BUS'(1);
    localparam logic [MEM_OP_BUS-1:0]  OP_STORE     = MEM_OP_BUS'(2);
    localparam logic [ISA_EXP_BUS-1:0] EXP_NONE     = '0;
    localparam logic [ISA_EXP_BUS-1:0] EXP_MISALIGN = ISA_EXP_BUS'(4);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t state, state_nxt;
    logic   drop, drop_nxt;

    // Buffer for the instruction whose access outlives its IDLE cycle.
    logic [WORD_ADDR_WIDTH-1:0] b_pc;
    logic                       b_br;
    logic [CTRL_OP_BUS-1:0]     b_ctrl;
    logic [REG_ADDR_BUS-1:0]    b_dst;
    logic                       b_wre;
    logic                       b_rw;
    logic [WORD_ADDR_WIDTH-1:0] b_addr;
    logic [WORD_DATA_WIDTH-1:0] b_wdata;
    logic [WORD_DATA_WIDTH-1:0] b_out;

    logic is_load, is_store, misalign, access;
    logic req, rw, busy, latch, park, kill;
    logic [WORD_ADDR_WIDTH-1:0] addr;
    logic [WORD_DATA_WIDTH-1:0] wdata;

    // Candidate MEM->WB contents for the coming edge.
    logic [WORD_ADDR_WIDTH-1:0] c_pc;
    logic                       c_en;
    logic                       c_br;
    logic [CTRL_OP_BUS-1:0]     c_ctrl;
    logic [REG_ADDR_BUS-1:0]    c_dst;
    logic                       c_wre;
    logic [ISA_EXP_BUS-1:0]     c_exp;
    logic [WORD_DATA_WIDTH-1:0] c_out;

    assign is_load  = (exe_mem_op_i == OP_LOAD);
    assign is_store = (exe_mem_op_i == OP_STORE);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = (is_load || is_store) && (exe_out_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign access = exe_en_i && (exe_exp_code_i == EXP_NONE)
                    && (is_load || is_store) && !misalign;

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        req       = 1'b0;
        rw        = 1'b0;
        addr      = '0;
        wdata     = '0;
        busy      = 1'b0;
        latch     = 1'b0;
        park      = 1'b0;
        kill      = 1'b0;
        c_pc      = exe_pc_i;
        c_en      = exe_en_i;
        c_br      = exe_br_flag_i;
        c_ctrl    = exe_ctrl_op_i;
        c_dst     = exe_dst_addr_i;
        c_wre     = exe_gpr_wre_i && !is_store && !misalign
                    && (exe_exp_code_i == EXP_NONE);
        c_exp     = (exe_exp_code_i != EXP_NONE) ? exe_exp_code_i
                  : misalign ? EXP_MISALIGN : EXP_NONE;
        c_out     = (access && is_load) ? bus_rd_data_i : exe_out_i;
        unique case (state)
            IDLE: begin
                if (access) begin
                    req   = 1'b1;
                    rw    = is_load;
                    addr  = exe_out_i[WORD_ADDR_WIDTH+1:2];
                    wdata = exe_mem_wr_data_i;
                    // A flush can't withdraw the request; remember to drop it.
                    drop_nxt = flush_i;
                    if (!bus_rdy_i) begin
                        busy      = 1'b1;
                        latch     = 1'b1;
                        state_nxt = WAIT;
                    end else if (stall_i) begin
                        latch     = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        drop_nxt = 1'b0;
                    end
                end
            end
            WAIT: begin
                req      = 1'b1;
                rw       = b_rw;
                addr     = b_addr;
                wdata    = b_wdata;
                c_pc     = b_pc;
                c_en     = 1'b1;
                c_br     = b_br;
                c_ctrl   = b_ctrl;
                c_dst    = b_dst;
                c_wre    = b_wre;
                c_exp    = EXP_NONE;
                c_out    = b_rw ? bus_rd_data_i : b_out;
                drop_nxt = drop | flush_i;
                if (!bus_rdy_i) begin
                    busy = 1'b1;
                end else if (drop || flush_i) begin
                    kill      = 1'b1;
                    drop_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (stall_i) begin
                    park      = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                c_pc     = b_pc;
                c_en     = 1'b1;
                c_br     = b_br;
                c_ctrl   = b_ctrl;
                c_dst    = b_dst;
                c_wre    = b_wre;
                c_exp    = EXP_NONE;
                c_out    = b_out;
                drop_nxt = drop | flush_i;
                if (!stall_i) begin
                    kill      = drop | flush_i;
                    drop_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is asserted.
    assign bus_req_o     = req & rst_n_i;
    assign bus_rw_o      = rw & rst_n_i;
    assign bus_addr_o    = addr & {WORD_ADDR_WIDTH{rst_n_i}};
    assign bus_wr_data_o = wdata & {WORD_DATA_WIDTH{rst_n_i}};
    assign busy_o        = busy & rst_n_i;
    assign fwd_data_o    = c_out & {WORD_DATA_WIDTH{rst_n_i}};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            drop    <= 1'b0;
            b_pc    <= '0;
            b_br    <= 1'b0;
            b_ctrl  <= '0;
            b_dst   <= '0;
            b_wre   <= 1'b0;
            b_rw    <= 1'b0;
            b_addr  <= '0;
            b_wdata <= '0;
            b_out   <= '0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            if (latch) begin
                b_pc    <= exe_pc_i;
                b_br    <= exe_br_flag_i;
                b_ctrl  <= exe_ctrl_op_i;
                b_dst   <= exe_dst_addr_i;
                b_wre   <= exe_gpr_wre_i && !is_store;
                b_rw    <= is_load;
                b_addr  <= exe_out_i[WORD_ADDR_WIDTH+1:2];
                b_wdata <= exe_mem_wr_data_i;
                // Load data is only valid now if the bus already answered.
                b_out   <= bus_rdy_i ? c_out : exe_out_i;
            end else if (park) begin
                b_out <= c_out;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_pc_o       <= '0;
            mem_en_o       <= 1'b0;
            mem_br_flag_o  <= 1'b0;
            mem_ctrl_op_o  <= '0;
            mem_dst_addr_o <= '0;
            mem_gpr_wre_o  <= 1'b0;
            mem_exp_code_o <= '0;
            mem_out_o      <= '0;
        end else if (!stall_i) begin
            if (flush_i || kill) begin
                mem_pc_o       <= '0;
                mem_en_o       <= 1'b0;
                mem_br_flag_o  <= 1'b0;
                mem_ctrl_op_o  <= '0;
                mem_dst_addr_o <= '0;
                mem_gpr_wre_o  <= 1'b0;
                mem_exp_code_o <= '0;
                mem_out_o      <= '0;
            end else begin
                mem_pc_o       <= c_pc;
                mem_en_o       <= c_en && !busy;
                mem_br_flag_o  <= c_br;
                mem_ctrl_op_o  <= c_ctrl;
                mem_dst_addr_o <= c_dst;
                mem_gpr_wre_o  <= c_en && !busy && c_wre;
                mem_exp_code_o <= (c_en && !busy) ? c_exp : EXP_NONE;
                mem_out_o      <= c_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against
// a transaction-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] fwd;
    logic [29:0] exe_pc = '0;
    logic        exe_en = 1'b0;
    logic        exe_br = 1'b0;
    logic [1:0]  exe_op = '0;
    logic [31:0] exe_wdata = '0;
    logic [1:0]  exe_ctrl = '0;
    logic [4:0]  exe_dst = '0;
    logic        exe_wre = 1'b0;
    logic [2:0]  exe_exc = '0;
    logic [31:0] exe_out = '0;
    logic        bus_req;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rd = '0;
    logic        bus_rdy = 1'b0;
    logic [29:0] mem_pc;
    logic        mem_en;
    logic        mem_br;
    logic [1:0]  mem_ctrl;
    logic [4:0]  mem_dst;
    logic        mem_wre;
    logic [2:0]  mem_exp;
    logic [31:0] mem_out;

    int checks = 0;
    int errors = 0;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .stall_i(stall), .flush_i(flush),
        .busy_o(busy), .fwd_data_o(fwd),
        .exe_pc_i(exe_pc), .exe_en_i(exe_en),
        .exe_br_flag_i(exe_br), .exe_mem_op_i(exe_op),
        .exe_mem_wr_data_i(exe_wdata), .exe_ctrl_op_i(exe_ctrl),
        .exe_dst_addr_i(exe_dst), .exe_gpr_wre_i(exe_wre),
        .exe_exp_code_i(exe_exc), .exe_out_i(exe_out),
        .bus_req_o(bus_req), .bus_rw_o(bus_rw),
        .bus_addr_o(bus_addr), .bus_wr_data_o(bus_wdata),
        .bus_rd_data_i(bus_rd), .bus_rdy_i(bus_rdy),
        .mem_pc_o(mem_pc), .mem_en_o(mem_en),
        .mem_br_flag_o(mem_br), .mem_ctrl_op_o(mem_ctrl),
        .mem_dst_addr_o(mem_dst), .mem_gpr_wre_o(mem_wre),
        .mem_exp_code_o(mem_exp), .mem_out_o(mem_out)
    );

    typedef struct packed {
        logic        issue;
        logic        rw;
        logic [29:0] waddr;
        logic [31:0] out;
        logic        en;
        logic        wre;
        logic [2:0]  exp;
    } exp_t;

    // Expected outcome of one instruction, straight from the ISA rules.
    function automatic exp_t model(input logic en, input logic [1:0] op,
                                   input logic [2:0] exc, input logic [31:0] a,
                                   input logic wre, input logic [31:0] rd);
        exp_t r;
        logic ls;
        logic mis;
        ls = (op == 2'd1) || (op == 2'd2);
        mis = CHECK_EN && ls && ((a % 4) != 0);
        r.issue = en && (exc == 0) && ls && !mis;
        r.rw = (op == 2'd1);
        r.waddr = 30'(a / 4);
        r.out = (r.issue && op == 2'd1) ? rd : a;
        r.en = en;
        r.exp = !en ? 3'd0 : (exc != 0) ? exc : mis ? 3'd4 : 3'd0;
        r.wre = en && wre && (op != 2'd2) && (r.exp == 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic en, input logic [1:0] op,
                             input logic [2:0] exc, input logic [31:0] a,
                             input logic [31:0] wd, input logic wre,
                             input logic [29:0] pc, input logic [4:0] dst);
        exe_en = en;
        exe_op = op;
        exe_exc = exc;
        exe_out = a;
        exe_wdata = wd;
        exe_wre = wre;
        exe_pc = pc;
        exe_dst = dst;
        exe_br = 1'($urandom);
        exe_ctrl = 2'($urandom);
    endtask

    task automatic nop();
        exe_en = 1'b0;
        exe_op = 2'd0;
        exe_exc = 3'd0;
        bus_rdy = 1'b0;
    endtask

    exp_t        e;
    logic [31:0] rd;
    logic [31:0] ra;
    int          w;
    int          nbusy;
    int          nreq;

    initial begin
        // Reset with an access presented: nothing may leak out.
        set_instr(1'b1, 2'd1, 3'd0, 32'h100, 32'h0, 1'b1, 30'h11, 5'd3);
        bus_rdy = 1'b1;
        #3;
        chk("rst_req", bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fwd", fwd, 0);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_out", mem_out, 0);
        chk("rst_mem_exp", mem_exp, 0);
        nop();
        rst_n = 1'b1;
        tick();

        // Zero-wait load.
        set_instr(1'b1, 2'd1, 3'd0, 32'h100, 32'h0, 1'b1, 30'h123, 5'd7);
        bus_rdy = 1'b1;
        bus_rd = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld0_req", bus_req, 1);
        chk("ld0_rw", bus_rw, 1);
        chk("ld0_addr", bus_addr, 32'h40);
        chk("ld0_busy", busy, 0);
        chk("ld0_fwd", fwd, 32'hDEADBEEF);
        tick();
        chk("ld0_out", mem_out, 32'hDEADBEEF);
        chk("ld0_en", mem_en, 1);
        chk("ld0_wre", mem_wre, 1);
        chk("ld0_dst", mem_dst, 7);
        chk("ld0_pc", mem_pc, 32'h123);
        nop();

        // Store with 3 wait states.
        set_instr(1'b1, 2'd2, 3'd0, 32'h204, 32'h12345678, 1'b0, 30'h55, 5'd0);
        nbusy = 0;
        for (int c = 0; c < 4; c++) begin
            bus_rdy = (c == 3);
            @(negedge clk);
            chk("st_req", bus_req, 1);
            chk("st_addr", bus_addr, 32'h81);
            chk("st_rw", bus_rw, 0);
            chk("st_wd", bus_wdata, 32'h12345678);
            if (busy) nbusy++;
            tick();
            if (c == 0) chk("st_bubble", mem_en, 0);
        end
        chk("st_nbusy", nbusy, 3);
        chk("st_en", mem_en, 1);
        chk("st_wre", mem_wre, 0);
        chk("st_out", mem_out, 32'h204);
        nop();

        // Load completing while stalled.
        rd = $urandom;
        set_instr(1'b1, 2'd1, 3'd0, 32'h3F0, 32'h0, 1'b1, 30'h77, 5'd9);
        bus_rd = rd;
        nreq = 0;
        bus_rdy = 1'b0;
        @(negedge clk);
        if (bus_req) nreq++;
        tick();
        stall = 1'b1;
        bus_rdy = 1'b1;
        @(negedge clk);
        if (bus_req) nreq++;
        chk("stl_busy1", busy, 0);
        tick();
        bus_rdy = 1'b0;
        bus_rd = ~rd;
        @(negedge clk);
        if (bus_req) nreq++;
        chk("stl_busy2", busy, 0);
        tick();
        chk("stl_hold", mem_en, 0);
        stall = 1'b0;
        @(negedge clk);
        if (bus_req) nreq++;
        tick();
        chk("stl_nreq", nreq, 2);
        chk("stl_out", mem_out, rd);
        chk("stl_en", mem_en, 1);
        chk("stl_wre", mem_wre, 1);
        chk("stl_dst", mem_dst, 9);
        nop();

        // Misaligned load.
        rd = $urandom;
        e = model(1'b1, 2'd1, 3'd0, 32'h102, 1'b1, rd);
        set_instr(1'b1, 2'd1, 3'd0, 32'h102, 32'h0, 1'b1, 30'h9, 5'd4);
        bus_rdy = 1'b1;
        bus_rd = rd;
        @(negedge clk);
        chk("mis_req", bus_req, e.issue);
        if (e.issue) chk("mis_addr", bus_addr, 32'h40);
        tick();
        chk("mis_exp", mem_exp, e.exp);
        chk("mis_wre", mem_wre, e.wre);
        chk("mis_en", mem_en, 1);
        chk("mis_out", mem_out, e.out);
        nop();

        // Flush during WAIT.
        set_instr(1'b1, 2'd1, 3'd0, 32'h300, 32'h0, 1'b1, 30'h31, 5'd5);
        bus_rd = $urandom;
        for (int c = 0; c < 4; c++) begin
            bus_rdy = (c == 3);
            flush = (c == 1);
            @(negedge clk);
            chk("fl_req", bus_req, 1);
            tick();
            if (c == 1) chk("fl_clear", mem_pc, 0);
        end
        flush = 1'b0;
        chk("fl_en", mem_en, 0);
        chk("fl_wre", mem_wre, 0);
        nop();

        // Flush together with rdy.
        set_instr(1'b1, 2'd1, 3'd0, 32'h304, 32'h0, 1'b1, 30'h32, 5'd6);
        bus_rd = $urandom;
        tick();
        flush = 1'b1;
        bus_rdy = 1'b1;
        tick();
        flush = 1'b0;
        chk("flr_en", mem_en, 0);
        chk("flr_out", mem_out, 0);
        nop();
        @(negedge clk);
        chk("flr_idle", bus_req, 0);
        tick();

        // Upstream exception passes through without a bus access.
        set_instr(1'b1, 2'd1, 3'd2, 32'h400, 32'h0, 1'b1, 30'h44, 5'd8);
        @(negedge clk);
        chk("exc_req", bus_req, 0);
        tick();
        chk("exc_code", mem_exp, 2);
        chk("exc_wre", mem_wre, 0);
        nop();

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            logic        r_en;
            logic [1:0]  r_op;
            logic [2:0]  r_exc;
            logic        r_wre;
            logic [29:0] r_pc;
            logic [4:0]  r_dst;
            logic [31:0] r_wd;
            r_en = ($urandom_range(0, 9) != 0);
            r_op = 2'($urandom);
            r_exc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            r_wre = 1'($urandom);
            r_pc = 30'($urandom);
            r_dst = 5'($urandom);
            r_wd = $urandom;
            rd = $urandom;
            w = $urandom_range(0, 3);
            e = model(r_en, r_op, r_exc, ra, r_wre, rd);
            set_instr(r_en, r_op, r_exc, ra, r_wd, r_wre, r_pc, r_dst);
            bus_rd = rd;
            for (int c = 0; c <= w; c++) begin
                bus_rdy = e.issue && (c == w);
                @(negedge clk);
                chk("rnd_req", bus_req, e.issue);
                chk("rnd_busy", busy, e.issue && (c < w));
                if (e.issue) begin
                    chk("rnd_addr", bus_addr, e.waddr);
                    chk("rnd_rw", bus_rw, e.rw);
                    if (!e.rw) chk("rnd_wd", bus_wdata, r_wd);
                end
                tick();
                if (!e.issue) break;
            end
            chk("rnd_en", mem_en, e.en);
            chk("rnd_wre", mem_wre, e.wre);
            chk("rnd_exp", mem_exp, e.exp);
            if (e.en) begin
                chk("rnd_out", mem_out, e.out);
                chk("rnd_pc", mem_pc, r_pc);
                chk("rnd_dst", mem_dst, r_dst);
            end
            nop();
        end

        // Reset in the middle of a WAIT.
        set_instr(1'b1, 2'd1, 3'd0, 32'h500, 32'h0, 1'b1, 30'h66, 5'd2);
        bus_rd = $urandom;
        tick();
        @(negedge clk);
        chk("rw_req_before", bus_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rw_req", bus_req, 0);
        chk("rw_busy", busy, 0);
        chk("rw_pc", mem_pc, 0);
        chk("rw_out", mem_out, 0);
        chk("rw_fwd", fwd, 0);
        nop();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rw_idle_req", bus_req, 0);
        tick();
        rd = $urandom;
        set_instr(1'b1, 2'd1, 3'd0, 32'h600, 32'h0, 1'b1, 30'h67, 5'd1);
        bus_rdy = 1'b1;
        bus_rd = rd;
        @(negedge clk);
        chk("rw_new_addr", bus_addr, 32'h180);
        tick();
        chk("rw_new_out", mem_out, rd);
        chk("rw_new_en", mem_en, 1);
        nop();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
